// File: rtl/operation_sequencer.sv
// operation_sequencer
// Back end of the control unit. Captures the decoder's four micro-operation
// slots when a new instruction is decoded. It then issues one operation code at
// a time to the datapath and holds each code until the datapath acknowledges it.
// A sequence ends at the READ_INST code (next fetch), at HALT, or in ERROR
// when slot 4 is not a terminator or when the per-step watchdog expires.
module operation_sequencer #(
    parameter int unsigned                        operation_code_length = 4,
    parameter logic [operation_code_length-1:0]   READ_INST_CODE        = 4'd1,
    parameter logic [operation_code_length-1:0]   HALT_CODE             = 4'd15,
    parameter logic [operation_code_length-1:0]   NOP_CODE              = 4'd0,
    parameter int unsigned                        TIMEOUT_CYCLES        = 32'd64
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               IR_VALID,
    input  logic [operation_code_length-1:0]   OPER_CODE_1,
    input  logic [operation_code_length-1:0]   OPER_CODE_2,
    input  logic [operation_code_length-1:0]   OPER_CODE_3,
    input  logic [operation_code_length-1:0]   OPER_CODE_4,
    input  logic                               OPER_DONE,
    input  logic                               ERR_CLR,
    output logic [operation_code_length-1:0]   OPER_CODE,
    output logic                               OPER_VALID,
    output logic [1:0]                         STEP,
    output logic                               BUSY,
    output logic                               INSTR_DONE,
    output logic                               HALTED,
    output logic                               SEQ_ERROR
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT_CYCLES);
    localparam bit              WD_ENABLE = (TIMEOUT_CYCLES != 32'd0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t                             state_r;
    logic [operation_code_length-1:0]   slot_r [4];
    logic [1:0]                         step_r;
    logic [operation_code_length-1:0]   oper_code_r;
    logic                               oper_valid_r;
    logic                               busy_r;
    logic                               instr_done_r;
    logic                               halted_r;
    logic                               seq_error_r;
    logic [WD_W-1:0]                    wdog_r;

    logic [1:0]                         step_inc_s;
    logic [operation_code_length-1:0]   cur_code_s;
    logic [operation_code_length-1:0]   next_code_s;
    logic [WD_W-1:0]                    wdog_inc_s;
    logic                               wdog_expire_s;

    // Current/next slot selection and watchdog expiry for the running step
    always_comb begin
        step_inc_s    = step_r + 2'd1;
        cur_code_s    = slot_r[step_r];
        next_code_s   = slot_r[step_inc_s];
        wdog_inc_s    = wdog_r + WD_W'(1'b1);
        wdog_expire_s = WD_ENABLE && (wdog_inc_s >= WD_LIMIT);
    end

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                slot_r[i] <= {operation_code_length{1'b0}};
            end
            step_r       <= 2'd0;
            oper_code_r  <= NOP_CODE;
            oper_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            instr_done_r <= 1'b0;
            halted_r     <= 1'b0;
            seq_error_r  <= 1'b0;
            wdog_r       <= {WD_W{1'b0}};
        end else begin
            instr_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (IR_VALID) begin
                        slot_r[0]    <= OPER_CODE_1;
                        slot_r[1]    <= OPER_CODE_2;
                        slot_r[2]    <= OPER_CODE_3;
                        slot_r[3]    <= OPER_CODE_4;
                        step_r       <= 2'd0;
                        oper_code_r  <= OPER_CODE_1;
                        oper_valid_r <= 1'b1;
                        busy_r       <= 1'b1;
                        wdog_r       <= {WD_W{1'b0}};
                        state_r      <= ST_RUN;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cur_code_s == HALT_CODE) begin
                        // HALT does not wait for the datapath acknowledge
                        oper_code_r  <= NOP_CODE;
                        oper_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        halted_r     <= 1'b1;
                        state_r      <= ST_HALTED;
                    end else if (OPER_DONE) begin
                        wdog_r <= {WD_W{1'b0}};
                        if (cur_code_s == READ_INST_CODE) begin
                            oper_code_r  <= NOP_CODE;
                            oper_valid_r <= 1'b0;
                            busy_r       <= 1'b0;
                            instr_done_r <= 1'b1;
                            step_r       <= 2'd0;
                            state_r      <= ST_IDLE;
                        end else if (step_r != 2'd3) begin
                            step_r      <= step_inc_s;
                            oper_code_r <= next_code_s;
                        end else begin
                            // Slot 4 acknowledged without a terminator
                            oper_code_r  <= NOP_CODE;
                            oper_valid_r <= 1'b0;
                            busy_r       <= 1'b0;
                            seq_error_r  <= 1'b1;
                            state_r      <= ST_ERROR;
                        end
                    end else if (wdog_expire_s) begin
                        oper_code_r  <= NOP_CODE;
                        oper_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        seq_error_r  <= 1'b1;
                        wdog_r       <= {WD_W{1'b0}};
                        state_r      <= ST_ERROR;
                    end else begin
                        wdog_r <= wdog_inc_s;
                    end
                end
                ST_HALTED: begin
                    state_r <= ST_HALTED;
                end
                ST_ERROR: begin
                    if (ERR_CLR) begin
                        seq_error_r <= 1'b0;
                        step_r      <= 2'd0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_ERROR;
                    end
                end
                default: begin
                    oper_code_r  <= NOP_CODE;
                    oper_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    step_r       <= 2'd0;
                    wdog_r       <= {WD_W{1'b0}};
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign OPER_CODE  = oper_code_r;
    assign OPER_VALID = oper_valid_r;
    assign STEP       = step_r;
    assign BUSY       = busy_r;
    assign INSTR_DONE = instr_done_r;
    assign HALTED     = halted_r;
    assign SEQ_ERROR  = seq_error_r;

endmodule

// File: tb/tb_operation_sequencer.sv
// Testbench for operation_sequencer. A transaction-level model expands each
// instruction (slots plus a per-step acknowledge delay) into a per-cycle list of
// inputs and expected outputs. One compare process checks every listed cycle.
`timescale 1ns/1ps
module tb_operation_sequencer;

    localparam int TMO = 8;
    localparam int R_DONE = 0;
    localparam int R_HALT = 1;
    localparam int R_ERR  = 2;

    localparam logic [3:0] C_NOP       = 4'd0;
    localparam logic [3:0] C_READ_INST = 4'd1;
    localparam logic [3:0] C_READ_REGS = 4'd2;
    localparam logic [3:0] C_ALU_RUN   = 4'd3;
    localparam logic [3:0] C_WRITE_REG = 4'd4;
    localparam logic [3:0] C_HALT      = 4'd15;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       IR_VALID;
    logic [3:0] OPER_CODE_1, OPER_CODE_2, OPER_CODE_3, OPER_CODE_4;
    logic       OPER_DONE;
    logic       ERR_CLR;
    logic [3:0] OPER_CODE;
    logic       OPER_VALID;
    logic [1:0] STEP;
    logic       BUSY, INSTR_DONE, HALTED, SEQ_ERROR;

    always #5 CLK = ~CLK;

    operation_sequencer #(
        .operation_code_length (4),
        .READ_INST_CODE        (C_READ_INST),
        .HALT_CODE             (C_HALT),
        .NOP_CODE              (C_NOP),
        .TIMEOUT_CYCLES        (TMO)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IR_VALID    (IR_VALID),
        .OPER_CODE_1 (OPER_CODE_1),
        .OPER_CODE_2 (OPER_CODE_2),
        .OPER_CODE_3 (OPER_CODE_3),
        .OPER_CODE_4 (OPER_CODE_4),
        .OPER_DONE   (OPER_DONE),
        .ERR_CLR     (ERR_CLR),
        .OPER_CODE   (OPER_CODE),
        .OPER_VALID  (OPER_VALID),
        .STEP        (STEP),
        .BUSY        (BUSY),
        .INSTR_DONE  (INSTR_DONE),
        .HALTED      (HALTED),
        .SEQ_ERROR   (SEQ_ERROR)
    );

    typedef struct {
        logic        ir;
        logic [15:0] slots;
        logic        done;
        logic        clr;
        logic        ev;
        logic [3:0]  ecode;
        logic [1:0]  estep;
        logic        chk_step;
        logic        ebusy;
        logic        eidone;
        logic        ehalt;
        logic        eerr;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    ent_t tmp_e;
    bit   chk_en     = 1'b0;
    bit   pend_idone = 1'b0;
    int   n_assert   = 0;
    int   n_fail     = 0;
    int   mon_valid  = 0;
    int   mon_idone  = 0;
    int   base_v, base_i, res, es;
    logic [15:0] rs, rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model's expected outputs
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("oper_valid", 32'(OPER_VALID), 32'(cur.ev));
            chk("oper_code",  32'(OPER_CODE),  32'(cur.ecode));
            chk("busy",       32'(BUSY),       32'(cur.ebusy));
            chk("instr_done", 32'(INSTR_DONE), 32'(cur.eidone));
            chk("halted",     32'(HALTED),     32'(cur.ehalt));
            chk("seq_error",  32'(SEQ_ERROR),  32'(cur.eerr));
            if (cur.chk_step) chk("step", 32'(STEP), 32'(cur.estep));
        end
    end

    // Activity counters used by the hand-computed expectations
    always @(negedge CLK) begin
        if (OPER_VALID) mon_valid++;
        if (INSTR_DONE) mon_idone++;
    end

    function automatic logic rbit();
        return ($urandom_range(0, 1) == 1);
    endfunction

    function automatic logic irr(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 2) return 1'b1;
        return ($urandom_range(0, 3) == 0);
    endfunction

    function automatic logic [15:0] rnd16();
        return 16'($urandom);
    endfunction

    task automatic add(input logic ir, input logic [15:0] g, input logic done, input logic clr,
                       input logic ev, input logic [3:0] ec, input logic [1:0] esv, input logic cs,
                       input logic eb, input logic eh, input logic ee);
        ent_t e;
        e.ir = ir; e.slots = g; e.done = done; e.clr = clr;
        e.ev = ev; e.ecode = ec; e.estep = esv; e.chk_step = cs;
        e.ebusy = eb; e.ehalt = eh; e.eerr = ee;
        e.eidone = pend_idone;
        pend_idone = 1'b0;
        q.push_back(e);
    endtask

    task automatic add_idle(input logic ir, input logic [15:0] g);
        add(ir, g, rbit(), rbit(), 1'b0, C_NOP, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_valid(input int mode, input logic done, input logic [3:0] code, input int k);
        add(irr(mode), rnd16(), done, 1'b0, 1'b1, code, 2'(k), 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // Expand one instruction into cycles: the IR_VALID cycle, then each issued slot
    task automatic run_instr(input logic [15:0] slots, input logic [15:0] dl, input int mode,
                             output int r, output int ek);
        logic [3:0] code;
        int d;
        r  = R_ERR;
        ek = 0;
        add(1'b1, slots, rbit(), rbit(), 1'b0, C_NOP, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            code = slots[k*4 +: 4];
            d    = int'(dl[k*4 +: 4]);
            ek   = k;
            if (code == C_HALT) begin
                add_valid(mode, 1'b0, code, k);
                r = R_HALT;
                return;
            end
            for (int i = 0; i < ((d >= TMO) ? TMO : d); i++) add_valid(mode, 1'b0, code, k);
            if (d >= TMO) begin
                r = R_ERR;
                return;
            end
            add_valid(mode, 1'b1, code, k);
            if (code == C_READ_INST) begin
                r = R_DONE;
                return;
            end
        end
        r = R_ERR;
    endtask

    // Cycles after the sequence ends: instr_done pulse, error hold and clear, or halt
    task automatic finish_instr(input int r, input int ek, input int gap);
        if (r == R_DONE) begin
            pend_idone = 1'b1;
            for (int i = 0; i < gap; i++) add_idle(1'b0, rnd16());
        end else if (r == R_ERR) begin
            for (int i = 0; i < $urandom_range(1, 3); i++)
                add(rbit(), rnd16(), rbit(), 1'b0, 1'b0, C_NOP, 2'(ek), 1'b1, 1'b0, 1'b0, 1'b1);
            add(1'b1, rnd16(), rbit(), 1'b1, 1'b0, C_NOP, 2'(ek), 1'b1, 1'b0, 1'b0, 1'b1);
            add_idle(1'b0, rnd16());
        end else begin
            for (int i = 0; i < 3; i++)
                add(rbit(), rnd16(), rbit(), rbit(), 1'b0, C_NOP, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic drive(input ent_t e);
        IR_VALID    = e.ir;
        OPER_CODE_1 = e.slots[3:0];
        OPER_CODE_2 = e.slots[7:4];
        OPER_CODE_3 = e.slots[11:8];
        OPER_CODE_4 = e.slots[15:12];
        OPER_DONE   = e.done;
        ERR_CLR     = e.clr;
    endtask

    task automatic drive_quiet();
        IR_VALID = 1'b0; OPER_DONE = 1'b0; ERR_CLR = 1'b0;
        OPER_CODE_1 = 4'd0; OPER_CODE_2 = 4'd0; OPER_CODE_3 = 4'd0; OPER_CODE_4 = 4'd0;
    endtask

    task automatic play();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge CLK); #1;
            cur    = e;
            chk_en = 1'b1;
            drive(e);
        end
        @(posedge CLK); #1;
        chk_en = 1'b0;
        drive_quiet();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_oper_valid"}, 32'(OPER_VALID), 32'd0);
        chk({tag, "_oper_code"},  32'(OPER_CODE),  32'(C_NOP));
        chk({tag, "_step"},       32'(STEP),       32'd0);
        chk({tag, "_busy"},       32'(BUSY),       32'd0);
        chk({tag, "_instr_done"}, 32'(INSTR_DONE), 32'd0);
        chk({tag, "_halted"},     32'(HALTED),     32'd0);
        chk({tag, "_seq_error"},  32'(SEQ_ERROR),  32'd0);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        chk_en = 1'b0;
        RST_N  = 1'b0;
        drive_quiet();
        #2;
        check_reset_vals("reset");
        @(posedge CLK); #1;
        RST_N      = 1'b1;
        pend_idone = 1'b0;
        q.delete();
    endtask

    function automatic logic [3:0] pick_code();
        int r;
        r = $urandom_range(0, 19);
        if (r < 4)  return C_READ_INST;
        if (r == 4) return C_HALT;
        if (r == 5) return C_NOP;
        return 4'($urandom_range(2, 4));
    endfunction

    function automatic logic [3:0] pick_delay();
        if ($urandom_range(0, 19) >= 18) return 4'($urandom_range(8, 12));
        return 4'($urandom_range(0, 7));
    endfunction

    initial begin
        RST_N = 1'b0;
        drive_quiet();
        do_reset();

        // Back-to-back acknowledges through a four-step instruction
        base_v = mon_valid; base_i = mon_idone;
        run_instr({C_READ_INST, C_WRITE_REG, C_ALU_RUN, C_READ_REGS}, 16'h0000, 0, res, es);
        finish_instr(res, es, 2);
        play();
        chk("t1_valid_cycles", 32'(mon_valid - base_v), 32'd4);
        chk("t1_instr_done",   32'(mon_idone - base_i), 32'd1);

        // Each code held three cycles, three steps
        base_v = mon_valid; base_i = mon_idone;
        run_instr({C_ALU_RUN, C_READ_INST, C_WRITE_REG, C_READ_REGS}, 16'h0222, 0, res, es);
        finish_instr(res, es, 2);
        play();
        chk("t2_valid_cycles", 32'(mon_valid - base_v), 32'd9);
        chk("t2_instr_done",   32'(mon_idone - base_i), 32'd1);

        // HALT in slot 1, inputs ignored afterwards
        base_v = mon_valid; base_i = mon_idone;
        run_instr({C_WRITE_REG, C_ALU_RUN, C_READ_INST, C_HALT}, 16'h0000, 0, res, es);
        finish_instr(res, es, 0);
        play();
        chk("t3_valid_cycles", 32'(mon_valid - base_v), 32'd1);
        chk("t3_halted",       32'(HALTED), 32'd1);
        chk("t3_instr_done",   32'(mon_idone - base_i), 32'd0);
        do_reset();

        // Watchdog: no acknowledge for the first step
        base_v = mon_valid;
        run_instr({C_READ_INST, C_WRITE_REG, C_ALU_RUN, C_READ_REGS}, 16'h000F, 0, res, es);
        finish_instr(res, es, 0);
        play();
        chk("t4_valid_cycles", 32'(mon_valid - base_v), 32'd8);

        // Four non-terminating slots
        base_v = mon_valid; base_i = mon_idone;
        run_instr({C_READ_REGS, C_READ_REGS, C_READ_REGS, C_READ_REGS}, 16'h0000, 0, res, es);
        finish_instr(res, es, 0);
        play();
        chk("t5_valid_cycles", 32'(mon_valid - base_v), 32'd4);
        chk("t5_instr_done",   32'(mon_idone - base_i), 32'd0);

        // Asynchronous reset in the middle of step 2
        run_instr({C_READ_INST, C_WRITE_REG, C_ALU_RUN, C_READ_REGS}, 16'h0500, 0, res, es);
        for (int i = 0; i < 4; i++) begin
            tmp_e = q.pop_front();
            @(posedge CLK); #1;
            cur    = tmp_e;
            chk_en = 1'b1;
            drive(tmp_e);
        end
        #1;
        chk("t6_step_before_reset",  32'(STEP), 32'd2);
        chk("t6_valid_before_reset", 32'(OPER_VALID), 32'd1);
        #1;
        chk_en = 1'b0;
        RST_N  = 1'b0;
        drive_quiet();
        #1;
        check_reset_vals("t6_async");
        q.delete();
        pend_idone = 1'b0;
        @(posedge CLK); #1;
        RST_N  = 1'b1;
        base_i = mon_idone;
        for (int i = 0; i < 3; i++) add_idle(1'b0, rnd16());
        play();
        chk("t6_no_instr_done", 32'(mon_idone - base_i), 32'd0);

        // IR_VALID pulsed with other slot values on every busy cycle
        base_v = mon_valid; base_i = mon_idone;
        run_instr({C_READ_INST, C_WRITE_REG, C_ALU_RUN, C_READ_REGS}, 16'h1111, 2, res, es);
        finish_instr(res, es, 1);
        play();
        chk("t7_valid_cycles", 32'(mon_valid - base_v), 32'd8);
        chk("t7_instr_done",   32'(mon_idone - base_i), 32'd1);

        // Randomized instruction stream
        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < 4; k++) begin
                rs[k*4 +: 4] = pick_code();
                rd[k*4 +: 4] = pick_delay();
            end
            run_instr(rs, rd, 1, res, es);
            finish_instr(res, es, $urandom_range(0, 2));
            if (res == R_HALT) begin
                play();
                do_reset();
            end
        end
        add_idle(1'b0, rnd16());
        play();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
